// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port between the access unit and memory.
// Latency: n/a (wiring only).
// Backpressure: memory stretches a transaction by withholding mem_ack while mem_req is high.
//
// Ports (modports):
//   master - access unit: drives mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata, samples mem_ack/mem_rdata
//   slave  - memory: the mirror image
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wstrb;
    logic [63:0]       mem_wdata;
    logic              mem_ack;
    logic [63:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: turns an EX/MEM load/store into one memory transaction and returns extended load data.
// Latency: 3 cycles minimum (IDLE->ACCESS->DONE), +1 per memory wait cycle.
// Backpressure: stall holds the upstream pipeline from the start cycle until mem_ack; the request is held until acked.
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   ex_*            - registered instruction from EX/MEM (valid, load/store, func3, address, store data, rd)
//   mem             - master side of the data-memory port
//   stall           - hold IF/ID, ID/EX, EX/MEM
//   wb_valid/rd/data- registered load result, valid in DONE only
//   fault           - single-cycle pulse on misaligned or illegal access
module mem_access_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_is_store,
    input  logic [2:0]       ex_func3,
    input  logic [XLEN-1:0]  ex_addr,
    input  logic [XLEN-1:0]  ex_wdata,
    input  logic [4:0]       ex_rd,
    mem_access_unit_if.master mem,
    output logic             stall,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Decode of the instruction sitting in EX/MEM
    logic [1:0]        sz;
    logic [2:0]        off;
    logic              start;
    logic              illegal;
    logic              misaligned;
    logic              bad;
    logic [7:0]        strb_c;
    logic [XLEN-1:0]   wdata_c;

    // Upper address bits do not reach the memory port
    logic unused_addr_hi;
    assign unused_addr_hi = ^ex_addr[XLEN-1:ADDR_W];

    assign sz    = ex_func3[1:0];
    assign off   = ex_addr[2:0];
    assign start = ex_valid & (ex_is_load | ex_is_store);
    assign bad   = illegal | misaligned;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        strb_c     = 8'h00;
        if (ex_is_load) illegal = (ex_func3 == 3'b111);
        else            illegal = ex_func3[2];
        case (sz)
            2'd0:    begin misaligned = 1'b0;        strb_c = 8'h01 << off; end
            2'd1:    begin misaligned = off[0];      strb_c = 8'h03 << off; end
            2'd2:    begin misaligned = |off[1:0];   strb_c = 8'h0F << off; end
            default: begin misaligned = |off;        strb_c = 8'hFF;        end
        endcase
        // Loads never write any lane
        if (!ex_is_store) strb_c = 8'h00;
    end

    assign wdata_c = ex_wdata << {off, 3'b000};

    // Next-state and control
    logic stall_c;
    logic fault_c;
    logic latch;

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        fault_c = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad) begin
                        fault_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        latch   = 1'b1;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (mem.mem_ack) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs are forced quiet while reset is held
    assign stall = stall_c & rst;
    assign fault = fault_c & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Latched request; kept after the op so the port stays stable
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [7:0]        r_wstrb;
    logic [63:0]       r_wdata;
    logic [4:0]        r_rd;
    logic [2:0]        r_func3;
    logic [2:0]        r_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wstrb <= 8'h00;
            r_wdata <= '0;
            r_rd    <= '0;
            r_func3 <= '0;
            r_off   <= '0;
        end else if (latch) begin
            r_addr  <= {ex_addr[ADDR_W-1:3], 3'b000};
            r_we    <= ex_is_store;
            r_wstrb <= strb_c;
            r_wdata <= wdata_c;
            r_rd    <= ex_rd;
            r_func3 <= ex_func3;
            r_off   <= off;
        end
    end

    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wstrb = r_wstrb;
    assign mem.mem_wdata = r_wdata;

    // Load alignment and extension
    logic [63:0] shifted;
    logic [63:0] ld_ext;

    assign shifted = mem.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        ld_ext = shifted;
        case (r_func3[1:0])
            2'd0:    ld_ext = r_func3[2] ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    ld_ext = r_func3[2] ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    ld_ext = r_func3[2] ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ld_ext = shifted;
        endcase
    end

    logic ack_now;
    assign ack_now = (state_q == ACCESS) & mem.mem_ack;

    // wb_valid is high exactly in the DONE cycle of a load to a real register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= ack_now & ~r_we & (r_rd != 5'd0);
            if (ack_now & ~r_we) begin
                wb_rd   <= r_rd;
                wb_data <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized loads/stores.
// Latency: n/a.
// Backpressure: memory side inserts 0..3 random wait cycles before mem_ack.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [2:0]  ex_func3 = '0;
    logic [63:0] ex_addr = '0;
    logic [63:0] ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        fault;

    mem_access_unit_if #(.ADDR_W(32)) mif ();

    mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_is_store(ex_is_store),
        .ex_func3   (ex_func3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd      (ex_rd),
        .mem        (mif),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory contents, indexed by address bits [9:3]
    logic [63:0] mem_model [128];

    // Observations of the most recent op, for literal checks
    logic [63:0] last_addr;
    logic [7:0]  last_strb;
    logic [63:0] last_wdata;
    logic        last_we;
    logic        last_wbv;
    logic [63:0] last_wb;
    logic        last_fault;
    logic        saw_req;
    int          stall_cycles;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // One instruction through the stage, checked cycle by cycle.
    task automatic do_op(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd, input int waits);
        bit          start, illegal, mis, bad, ewbv;
        int          nbytes;
        logic [1:0]  sz;
        logic [2:0]  a;
        logic [7:0]  estrb;
        logic [63:0] ewdata, edw, raw, mask, eval, emask;
        logic [6:0]  idx;

        start   = v && (ld || st);
        sz      = f3[1:0];
        a       = addr[2:0];
        illegal = ld ? (f3 == 3'b111) : f3[2];
        mis     = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd3 && a != 3'd0);
        bad     = illegal || mis;
        nbytes  = 1 << sz;
        estrb   = st ? 8'((((1 << nbytes) - 1) << a) & 255) : 8'h00;
        ewdata  = wd << (8 * a);
        idx     = addr[9:3];
        edw     = mem_model[idx];
        raw     = edw >> (8 * a);
        mask    = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        eval    = raw & mask;
        if (!f3[2] && nbytes < 8 && raw[8 * nbytes - 1]) eval = eval | ~mask;
        ewbv    = ld && (rd != 5'd0);
        emask   = '0;
        for (int i = 0; i < 8; i++) if (estrb[i]) emask[8*i +: 8] = 8'hFF;

        saw_req      = 1'b0;
        stall_cycles = 0;
        last_wbv     = 1'b0;

        @(posedge clk); #1;
        ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_func3 = f3;
        ex_addr = addr; ex_wdata = wd; ex_rd = rd;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = {$urandom, $urandom};

        @(negedge clk);
        chk("idle_stall", stall, start && !bad);
        chk("idle_fault", fault, start && bad);
        chk("idle_req", mif.mem_req, 1'b0);
        chk("idle_wbv", wb_valid, 1'b0);
        last_fault = fault;
        if (stall) stall_cycles++;
        if (!start || bad) return;

        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            mif.mem_ack   = (w == waits);
            mif.mem_rdata = (w == waits) ? edw : {$urandom, $urandom};
            @(negedge clk);
            chk("acc_req", mif.mem_req, 1'b1);
            chk("acc_stall", stall, 1'b1);
            chk("acc_fault", fault, 1'b0);
            chk("acc_we", mif.mem_we, st);
            chk("acc_addr", 64'(mif.mem_addr), {32'b0, addr[31:3], 3'b000});
            chk("acc_strb", mif.mem_wstrb, estrb);
            chk("acc_wdata", mif.mem_wdata & emask, ewdata & emask);
            chk("acc_wbv", wb_valid, 1'b0);
            if (stall) stall_cycles++;
            if (w == 0) begin
                saw_req    = mif.mem_req;
                last_addr  = 64'(mif.mem_addr);
                last_strb  = mif.mem_wstrb;
                last_wdata = mif.mem_wdata;
                last_we    = mif.mem_we;
            end
        end

        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        if (st) for (int i = 0; i < 8; i++) if (estrb[i]) mem_model[idx][8*i +: 8] = ewdata[8*i +: 8];

        @(negedge clk);
        chk("done_stall", stall, 1'b0);
        chk("done_req", mif.mem_req, 1'b0);
        chk("done_fault", fault, 1'b0);
        chk("done_wbv", wb_valid, ewbv);
        if (ewbv) begin
            chk("done_wbrd", wb_rd, rd);
            chk("done_wbdata", wb_data, eval);
        end
        last_wbv = wb_valid;
        last_wb  = wb_data;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = {$urandom, $urandom};
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;

        // Reset state, with a legal load presented: stall must stay low
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_func3 = 3'b011; ex_addr = 64'h100;
        #12;
        chk("rst_req", mif.mem_req, 1'b0);
        chk("rst_we", mif.mem_we, 1'b0);
        chk("rst_strb", mif.mem_wstrb, 8'h00);
        chk("rst_addr", 64'(mif.mem_addr), 64'h0);
        chk("rst_wdata", mif.mem_wdata, 64'h0);
        chk("rst_wbv", wb_valid, 1'b0);
        chk("rst_wbrd", wb_rd, 5'd0);
        chk("rst_wbdata", wb_data, 64'h0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_stall", stall, 1'b0);
        ex_valid = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Load double, zero wait
        mem_model[7'h20] = 64'h1122334455667788;
        do_op(1, 1, 0, 3'b011, 64'h100, 64'h0, 5'd5, 0);
        chk("lit_ld_addr", last_addr, 64'h100);
        chk("lit_ld_strb", last_strb, 8'h00);
        chk("lit_ld_stall", stall_cycles, 2);
        chk("lit_ld_wbv", last_wbv, 1'b1);
        chk("lit_ld_data", last_wb, 64'h1122334455667788);

        // Signed and unsigned byte load
        mem_model[7'h20] = 64'h0000_0000_8000_0000;
        do_op(1, 1, 0, 3'b000, 64'h103, 64'h0, 5'd7, 1);
        chk("lit_lb", last_wb, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(1, 1, 0, 3'b100, 64'h103, 64'h0, 5'd7, 0);
        chk("lit_lbu", last_wb, 64'h80);

        // Store half with three wait states
        do_op(1, 0, 1, 3'b001, 64'h206, 64'hABCD, 5'd3, 3);
        chk("lit_sh_we", last_we, 1'b1);
        chk("lit_sh_addr", last_addr, 64'h200);
        chk("lit_sh_strb", last_strb, 8'hC0);
        chk("lit_sh_data", last_wdata[63:48], 64'hABCD);
        chk("lit_sh_stall", stall_cycles, 5);
        chk("lit_sh_wbv", last_wbv, 1'b0);

        // Misaligned word load, illegal store code
        do_op(1, 1, 0, 3'b010, 64'h102, 64'h0, 5'd4, 0);
        chk("lit_mis_fault", last_fault, 1'b1);
        chk("lit_mis_req", saw_req, 1'b0);
        chk("lit_mis_stall", stall_cycles, 0);
        do_op(1, 0, 1, 3'b100, 64'h100, 64'h55, 5'd4, 0);
        chk("lit_ill_fault", last_fault, 1'b1);
        chk("lit_ill_req", saw_req, 1'b0);

        // Load to x0
        do_op(1, 1, 0, 3'b011, 64'h108, 64'h0, 5'd0, 2);
        chk("lit_x0_req", saw_req, 1'b1);
        chk("lit_x0_wbv", last_wbv, 1'b0);

        // Reset in the middle of an access
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
        ex_func3 = 3'b011; ex_addr = 64'h118; ex_rd = 5'd9;
        mif.mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_before", mif.mem_req, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("mid_req_rst", mif.mem_req, 1'b0);
        chk("mid_stall_rst", stall, 1'b0);
        chk("mid_addr_rst", 64'(mif.mem_addr), 64'h0);
        ex_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_req_after", mif.mem_req, 1'b0);
        chk("mid_stall_after", stall, 1'b0);
        do_op(1, 1, 0, 3'b010, 64'h11C, 64'h0, 5'd9, 1);
        chk("mid_new_wbv", last_wbv, 1'b1);

        // Randomized traffic, back to back
        for (int n = 0; n < 400; n++) begin
            bit          v, ld, st;
            logic [2:0]  f3;
            logic [63:0] addr;
            int          kind;
            kind = $urandom_range(0, 9);
            v    = (kind != 0);
            ld   = (kind >= 1 && kind <= 5);
            st   = (kind >= 6);
            if (kind == 9 && $urandom_range(0, 1) == 1) st = 1'b0;  // valid non-memory op
            f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3[2] = ld ? f3[2] : 1'b0;
            addr = {$urandom, 22'($urandom), 7'($urandom_range(0, 127)), 3'b000};
            if ($urandom_range(0, 2) == 0) addr[2:0] = 3'($urandom_range(0, 7));
            else case (f3[1:0])
                2'd0: addr[2:0] = 3'($urandom_range(0, 7));
                2'd1: addr[2:0] = {2'($urandom_range(0, 3)), 1'b0};
                2'd2: addr[2:0] = {1'($urandom_range(0, 1)), 2'b00};
                default: addr[2:0] = 3'b000;
            endcase
            do_op(v, ld, st, f3, addr, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage for the 5-stage 64-bit RISC-V pipeline, between the EX/MEM pipeline registers and the MEM/WB registers. It turns a registered load/store (address, store data, func3, rd) into a request/acknowledge transaction on a 64-bit data-memory port, holding the pipeline while that transaction is in flight. It returns load data aligned and sign/zero-extended for write-back. It replaces the tri-stated shared data bus with a separate request/acknowledge port so variable-latency memory can be used.

## Interface
- XLEN, 64, data width; fixed at 64 (8 byte lanes)
- ADDR_W, 32, width of mem_addr
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MEM holds a live instruction
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store (never together with ex_is_load)
- ex_func3  in  3  RV64 width/sign code
- ex_addr  in  64  effective address (EX/MEM result)
- ex_wdata  in  64  store data (EX/MEM data2)
- ex_rd  in  5  load destination register
- mem_req  out  1  request valid; held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  doubleword-aligned address, ex_addr[ADDR_W-1:3] concatenated with 3'b000
- mem_wstrb  out  8  byte-lane write enables
- mem_wdata  out  64  lane-shifted store data
- mem_ack  in  1  completion; valid only while mem_req=1
- mem_rdata  in  64  read data; valid with mem_ack on reads
- stall  out  1  hold the IF/ID, ID/EX and EX/MEM registers
- wb_valid  out  1  wb_data is load data for register wb_rd
- wb_rd  out  5  load destination
- wb_data  out  64  extended load result
- fault  out  1  one-cycle pulse: misaligned access or illegal func3

## Operation
- Start condition: start = ex_valid & (ex_is_load | ex_is_store).
- Lane offset: a = ex_addr[2:0].
- Sizes:
  - func3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double.
  - For loads, func3[2] = 1 means zero-extend.
  - Illegal codes: load func3 111; store func3[2] = 1.
- Misaligned: half with a[0] ≠ 0; word with a[1:0] ≠ 0; double with a ≠ 0.
- Write strobes: byte 8'h01<<a, half 8'h03<<a, word 8'h0F<<a, double 8'hFF.
- Store data: mem_wdata = ex_wdata << (8*a). Only strobed lanes are meaningful.
- Load data: shift mem_rdata >> (8*a), take the low 8/16/32/64 bits, then sign- or zero-extend to 64 bits.
- FSM states are IDLE, ACCESS and DONE.
  - IDLE:
    - If start and legal: latch addr, we, wstrb, wdata, rd and func3 into internal registers. stall=1 combinationally. Go to ACCESS.
    - If start and illegal or misaligned: fault=1 for this cycle, no request, stall=0, stay in IDLE. The instruction proceeds as a bubble with no write-back.
  - ACCESS:
    - mem_req=1 and stall=1; request outputs are driven from the latched registers.
    - On mem_ack: capture the extended load data into wb_data and go to DONE.
  - DONE:
    - stall=0. wb_valid=1 for one cycle if the op was a load with rd ≠ 0; otherwise wb_valid=0.
    - Go to IDLE. The EX/MEM registers advance at the end of this cycle, so the same op is not restarted.
- A load to x0 still performs the read, but wb_valid stays 0.
- mem_req never drops before mem_ack. Request outputs are stable while mem_req=1.
- A flush of EX/MEM does not affect an op already in ACCESS; the memory transaction always completes.

## Timing
- Reset (rst=0, asynchronous):
  - Outputs: state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, fault=0.
  - stall is combinational: while rst=0 it is forced to 0.
- Reset mid-transaction: mem_req drops immediately and the op is abandoned; the memory side must tolerate a withdrawn request.
- Latency, counted from the IDLE cycle with start:
  - mem_req rises at the next edge.
  - With same-cycle ack, DONE comes one edge later.
  - Minimum: 3 cycles in the unit, stall high for 2 cycles.
  - Each extra wait cycle before mem_ack adds one stall cycle.
- wb_valid, wb_rd and wb_data are registered; they are valid only in DONE. wb_data holds its value until the next load completes.
- fault is combinational from the EX/MEM inputs and is asserted only in IDLE.
- Back-to-back memory ops: the second op starts in the IDLE cycle right after DONE. Throughput is one memory op per 3 cycles at minimum.

## Test plan
- Load double, zero wait: ex_addr=0x100, func3=011, rd=5, mem_rdata=0x1122334455667788 with ack on the first ACCESS cycle.
  - Expect mem_addr=0x100, wstrb=0x00, stall high for 2 cycles.
  - Expect wb_valid=1, wb_rd=5, wb_data=0x1122334455667788 in DONE.
- Signed byte load: ex_addr=0x103, func3=000, mem_rdata=0x00000000_80000000 → wb_data=0xFFFFFFFFFFFFFF80.
  - Same access with func3=100 → wb_data=0x80.
- Store half with 3 wait states: ex_addr=0x206, ex_wdata=0xABCD, func3=001.
  - Expect mem_we=1, mem_addr=0x200, wstrb=0xC0, mem_wdata[63:48]=0xABCD.
  - Expect stall high for 5 cycles, request outputs stable throughout, wb_valid=0.
- Misaligned word load at 0x102: expect fault pulse, no mem_req, stall=0, wb_valid=0.
  - Store with func3=100: same response.
- Load with rd=0: expect mem_req issued and ack consumed, wb_valid=0.
- Reset during ACCESS (mem_ack held low, rst pulsed low):
  - Expect mem_req=0 and stall=0 immediately, state returns to IDLE.
  - A new load after reset completes normally.
